emergency_preempt: RTL and testbench

//  Conditions the raw emergency-vehicle sensor into the level `emergency` input

---
 rtl/emergency_preempt_if.sv | 26 ++
 rtl/emergency_preempt.sv | 163 ++++++++++++++++
 tb/tb_emergency_preempt.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/emergency_preempt_if.sv
// Emergency preemption signal bundle: raw sensor in, conditioned request out.
// There is no valid/ready handshake here. siren_raw is a free-running level,
// and every output is a registered level that can be sampled on any cycle.
interface emergency_preempt_if;
    logic       siren_raw;    // raw sensor, asynchronous to clk
    logic       emergency;    // preemption request (level)
    logic       fault;        // high while in FAULT
    logic [7:0] event_count;  // preemptions granted, saturating
    logic [2:0] dbg_state;    // current FSM state, for observation only

    modport master (
        output siren_raw,
        input  emergency,
        input  fault,
        input  event_count,
        input  dbg_state
    );

    modport slave (
        input  siren_raw,
        output emergency,
        output fault,
        output event_count,
        output dbg_state
    );
endinterface

// File: rtl/emergency_preempt.sv
// Emergency preemption conditioner. It synchronises and debounces the raw
// siren sensor, enforces a minimum hold and a release delay, and falls into
// FAULT when a preemption lasts too long (for example, a stuck sensor).
module emergency_preempt #(
    parameter int DEBOUNCE    = 4,
    parameter int MIN_HOLD    = 20,
    parameter int RELEASE_CYC = 6,
    parameter int MAX_HOLD    = 200,
    parameter int CW          = 8
) (
    input  logic          clk,
    input  logic          rst,
    emergency_preempt_if.slave bus
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_QUALIFY = 3'd1,
        S_ACTIVE  = 3'd2,
        S_RELEASE = 3'd3,
        S_FAULT   = 3'd4
    } state_t;

    localparam logic [CW-1:0] C_DEB_LAST = CW'(DEBOUNCE - 1);
    localparam logic [CW-1:0] C_MIN_HOLD = CW'(MIN_HOLD);
    localparam logic [CW-1:0] C_REL_LAST = CW'(RELEASE_CYC - 1);
    localparam logic [CW-1:0] C_MAX_LAST = CW'(MAX_HOLD - 1);
    localparam logic [CW-1:0] C_CNT_MAX  = {CW{1'b1}};

    logic          r_sync1;
    logic          r_sync2;
    state_t        r_state;
    logic [CW-1:0] r_q_cnt;
    logic [CW-1:0] r_hold_cnt;
    logic [CW-1:0] r_r_cnt;
    logic [7:0]    r_event_cnt;
    logic          r_emergency;
    logic          r_fault;

    state_t        w_state;
    logic [CW-1:0] w_q_cnt;
    logic [CW-1:0] w_hold_cnt;
    logic [CW-1:0] w_hold_inc;
    logic [CW-1:0] w_r_cnt;
    logic [7:0]    w_event_cnt;
    logic [7:0]    w_event_inc;
    logic          w_siren_s;

    assign w_siren_s   = r_sync2;
    assign w_hold_inc  = (r_hold_cnt == C_CNT_MAX) ? r_hold_cnt : r_hold_cnt + 1'b1;
    assign w_event_inc = (r_event_cnt == 8'hFF) ? r_event_cnt : r_event_cnt + 8'd1;

    // Two-flop synchroniser for the asynchronous sensor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= bus.siren_raw;
            r_sync2 <= r_sync1;
        end
    end

    // State, counter and registered-output update.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_q_cnt     <= '0;
            r_hold_cnt  <= '0;
            r_r_cnt     <= '0;
            r_event_cnt <= '0;
            r_emergency <= 1'b0;
            r_fault     <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_q_cnt     <= w_q_cnt;
            r_hold_cnt  <= w_hold_cnt;
            r_r_cnt     <= w_r_cnt;
            r_event_cnt <= w_event_cnt;
            r_emergency <= (w_state == S_ACTIVE) || (w_state == S_RELEASE);
            r_fault     <= (w_state == S_FAULT);
        end
    end

    // Next-state and counter logic. All decisions use current register values.
    always_comb begin
        w_state     = r_state;
        w_q_cnt     = r_q_cnt;
        w_hold_cnt  = r_hold_cnt;
        w_r_cnt     = r_r_cnt;
        w_event_cnt = r_event_cnt;
        case (r_state)
            S_IDLE: begin
                if (w_siren_s) begin
                    if (DEBOUNCE == 1) begin
                        w_state     = S_ACTIVE;
                        w_hold_cnt  = '0;
                        w_event_cnt = w_event_inc;
                    end else begin
                        w_state = S_QUALIFY;
                        w_q_cnt = CW'(1);
                    end
                end
            end
            S_QUALIFY: begin
                if (!w_siren_s) begin
                    w_state = S_IDLE;
                    w_q_cnt = '0;
                end else if (r_q_cnt == C_DEB_LAST) begin
                    w_state     = S_ACTIVE;
                    w_q_cnt     = '0;
                    w_hold_cnt  = '0;
                    w_event_cnt = w_event_inc;
                end else begin
                    w_q_cnt = r_q_cnt + 1'b1;
                end
            end
            S_ACTIVE: begin
                w_hold_cnt = w_hold_inc;
                if (r_hold_cnt == C_MAX_LAST) begin
                    w_state = S_FAULT;
                    w_r_cnt = '0;
                end else if (!w_siren_s && (r_hold_cnt >= C_MIN_HOLD)) begin
                    w_state = S_RELEASE;
                    w_r_cnt = '0;
                end
            end
            S_RELEASE: begin
                w_hold_cnt = w_hold_inc;
                if (r_hold_cnt == C_MAX_LAST) begin
                    w_state = S_FAULT;
                    w_r_cnt = '0;
                end else if (w_siren_s) begin
                    // Glitch during release: resume the hold without re-debouncing.
                    w_state = S_ACTIVE;
                end else if (r_r_cnt == C_REL_LAST) begin
                    w_state = S_IDLE;
                end else begin
                    w_r_cnt = r_r_cnt + 1'b1;
                end
            end
            S_FAULT: begin
                if (w_siren_s) begin
                    w_r_cnt = '0;
                end else if (r_r_cnt == C_REL_LAST) begin
                    w_state = S_IDLE;
                    w_r_cnt = '0;
                end else begin
                    w_r_cnt = r_r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase
    end

    assign bus.emergency   = r_emergency;
    assign bus.fault       = r_fault;
    assign bus.event_count = r_event_cnt;
    assign bus.dbg_state   = r_state;

endmodule

// File: tb/tb_emergency_preempt.sv
// Self-checking bench for emergency_preempt using the default parameters.
module tb_emergency_preempt;

    logic clk;
    logic rst;
    int   total;
    int   bad;

    emergency_preempt_if bus();

    emergency_preempt dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Clock and reset.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit         rst_first;
        logic       raw;
        int         n;
        logic       em;
        logic       ft;
        logic [7:0] cnt;
        string      name;
    } vec_t;

    vec_t vt[$];

    function automatic void add(bit rf, logic raw, int n, logic em, logic ft,
                                logic [7:0] cnt, string name);
        vec_t v;
        v.rst_first = rf;
        v.raw       = raw;
        v.n         = n;
        v.em        = em;
        v.ft        = ft;
        v.cnt       = cnt;
        v.name      = name;
        vt.push_back(v);
    endfunction

    task automatic check(string name, logic em, logic ft, logic [7:0] cnt);
        total++;
        if (bus.emergency !== em || bus.fault !== ft || bus.event_count !== cnt) begin
            bad++;
            $display("FAIL %s: got em=%0b ft=%0b cnt=%0d, expected em=%0b ft=%0b cnt=%0d",
                     name, bus.emergency, bus.fault, bus.event_count, em, ft, cnt);
        end
    endtask

    // Reset is applied and released on falling edges; the next rising edge is edge 0.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        bus.siren_raw = 1'b0;
        #2;
        total++;
        if (bus.emergency !== 1'b0 || bus.fault !== 1'b0 || bus.event_count !== 8'd0 ||
            bus.dbg_state !== 3'd0) begin
            bad++;
            $display("FAIL reset: got em=%0b ft=%0b cnt=%0d st=%0d, expected all 0",
                     bus.emergency, bus.fault, bus.event_count, bus.dbg_state);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full preemption: assert the siren long enough to qualify, then drop it
    // and wait (bounded) for emergency to go low.
    task automatic preempt_once(int idx);
        int k;
        bus.siren_raw = 1'b1;
        repeat (6) @(posedge clk);
        #1;
        bus.siren_raw = 1'b0;
        k = 0;
        while (bus.emergency && k < 60) begin
            @(posedge clk);
            #1;
            k++;
        end
        total++;
        if (bus.emergency !== 1'b0) begin
            bad++;
            $display("FAIL sat_release_%0d: emergency still %0b after %0d cycles, expected 0",
                     idx, bus.emergency, k);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b1;
        bus.siren_raw = 1'b0;
        repeat (2) @(posedge clk);

        // 3-cycle pulse never qualifies.
        add(1, 1,   3, 0, 0, 0, "t1_pulse3");
        add(0, 0,  10, 0, 0, 0, "t1_after");
        // 4-cycle pulse is the shortest that qualifies; hold runs from ACTIVE entry.
        add(1, 1,   4, 0, 0, 0, "p4_edge3");
        add(0, 0,   1, 0, 0, 0, "p4_edge4");
        add(0, 0,   1, 1, 0, 1, "p4_edge5");
        add(0, 0,  26, 1, 0, 1, "p4_edge31");
        add(0, 0,   1, 0, 0, 1, "p4_edge32");
        // Basic preemption: rise after edge 5, fall after edge 32.
        add(1, 1,   5, 0, 0, 0, "t2_edge4");
        add(0, 1,   1, 1, 0, 1, "t2_edge5");
        add(0, 1,   4, 1, 0, 1, "t2_edge9");
        add(0, 0,  22, 1, 0, 1, "t2_edge31");
        add(0, 0,   1, 0, 0, 1, "t2_edge32");
        // Glitch during RELEASE restarts it; emergency holds until edge 38.
        add(1, 1,  10, 1, 0, 1, "t3_edge9");
        add(0, 0,  18, 1, 0, 1, "t3_edge27");
        add(0, 1,   2, 1, 0, 1, "t3_edge29");
        add(0, 0,   8, 1, 0, 1, "t3_edge37");
        add(0, 0,   1, 0, 0, 1, "t3_edge38");
        // Stuck sensor: FAULT after edge 205, exit after edge 217, then re-debounce.
        add(1, 1,   6, 1, 0, 1, "t4_edge5");
        add(0, 1, 199, 1, 0, 1, "t4_edge204");
        add(0, 1,   1, 0, 1, 1, "t4_edge205");
        add(0, 1,   4, 0, 1, 1, "t4_edge209");
        add(0, 0,   7, 0, 1, 1, "t4_edge216");
        add(0, 0,   1, 0, 0, 1, "t4_edge217");
        add(0, 1,   5, 0, 0, 1, "t4_edge222");
        add(0, 1,   1, 1, 0, 2, "t4_edge223");

        for (int i = 0; i < vt.size(); i++) begin
            if (vt[i].rst_first) do_reset();
            bus.siren_raw = vt[i].raw;
            repeat (vt[i].n) @(posedge clk);
            #1;
            check(vt[i].name, vt[i].em, vt[i].ft, vt[i].cnt);
        end

        // Asynchronous reset while ACTIVE, then full latency again from release.
        do_reset();
        bus.siren_raw = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        check("t5_active", 1, 0, 1);
        #2;
        rst = 1'b1;
        #1;
        check("t5_async_rst", 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("t5_edge4", 0, 0, 0);
        @(posedge clk);
        #1;
        check("t5_edge5", 1, 0, 1);

        // Saturation: 256 preemptions leave event_count at 255.
        do_reset();
        for (int i = 1; i <= 256; i++) begin
            preempt_once(i);
            if (i == 1)   check("sat_1", 0, 0, 1);
            if (i == 254) check("sat_254", 0, 0, 254);
            if (i == 255) check("sat_255", 0, 0, 255);
        end
        check("sat_256", 0, 0, 255);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
